accum_dump_ctrl: RTL and testbench
==================================

ACCUM_DUMP_CTRL -- requirements
Module: accum_dump_ctrl

Interface
REQ-001 SHALL have parameter ACC_WIDTH, default 16, accumulator and dump data width.
REQ-002 SHALL have parameter PERIOD_WIDTH, default 2, width of the code periods per dump field.
REQ-003 SHALL have port clk  in  1  sample clock, same clock that drives the tracking channel.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  in  1  one-cycle pulse that arms the channel.
REQ-006 SHALL have port stop  in  1  one-cycle pulse that disarms the channel.
REQ-007 SHALL have port prn_in  in  5  PRN to track, captured on start.
REQ-008 SHALL have port period_in  in  PERIOD_WIDTH  C/A code periods (1 ms each) per dump, captured on start; the value 0 means 1.
REQ-009 SHALL have port code_shift  in  10  C/A code phase from the channel.
REQ-010 SHALL have port accumulator  in  ACC_WIDTH  free-running channel accumulator.
REQ-011 SHALL have port track_enable  out  1  channel clock enable.
REQ-012 SHALL have port track_prn  out  5  PRN presented to the channel.
REQ-013 SHALL have port dump_data  out  ACC_WIDTH  correlation sum for one dump period.
REQ-014 SHALL have port dump_valid  out  1  dump_data valid.
REQ-015 SHALL have port dump_ready  in  1  consumer accepts dump_data.
REQ-016 SHALL have port overrun  out  1  sticky flag: a dump was lost.
REQ-017 SHALL have port busy  out  1  high in every state except IDLE.

Function
REQ-018 SHALL implement the states IDLE, ARM and ACCUM.
REQ-019 SHALL define epoch as a one-cycle event: code_shift==0 while the registered previous code_shift is nonzero.
REQ-020 IDLE: track_enable=0; start moves to ARM, captures prn_in into track_prn, captures period_in, and clears the epoch count and overrun.
REQ-021 ARM: track_enable=1; on the first epoch, register accumulator as base, then go to ACCUM with the epoch count set to 0.
REQ-022 ACCUM: track_enable=1; increment the epoch count on each epoch; the epoch that makes the count equal the period is the dump epoch.
REQ-023 At the dump epoch: dump_data <= accumulator - base, modulo 2^ACC_WIDTH (wrap-around is correct by construction); base <= accumulator; count <= 0.
REQ-024 The dump epoch SHALL assert dump_valid in the next cycle (latency 1 clk from epoch).
REQ-025 Handshake: the transfer occurs when dump_valid and dump_ready are both high on a clk edge, and dump_valid drops the following cycle unless a new dump lands on that same edge.
REQ-026 While dump_valid is high and unaccepted, dump_data SHALL hold stable.
REQ-027 If a dump epoch occurs while dump_valid=1 and dump_ready=0, the new dump SHALL be dropped, dump_data kept, overrun set, and base still updated.
REQ-028 If dump_ready=1 coincides with a dump epoch, the new dump SHALL be loaded and dump_valid SHALL stay high without overrun.
REQ-029 stop in ARM or ACCUM SHALL return to IDLE next cycle, drop the partial period, and leave any pending dump_valid and dump_data intact until accepted.
REQ-030 start in ARM or ACCUM SHALL be ignored, and start and stop in the same cycle SHALL be treated as stop.
REQ-031 overrun SHALL clear only on reset or on an accepted start.

Reset
REQ-032 Reset SHALL asynchronously force IDLE and set track_enable=0, track_prn=0, dump_data=0, dump_valid=0, overrun=0, busy=0, base=0 and count=0.
REQ-033 Reset deassertion SHALL be synchronized to clk before the state machine leaves IDLE.

Configuration
REQ-034 Macro DUMP_OVERRUN_COUNT_EN, when defined, SHALL add output overrun_count (8 bits, saturating at 255, cleared like overrun) counting dropped dumps.
REQ-035 When DUMP_OVERRUN_COUNT_EN is not defined, the overrun_count port and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-036 Reset mid-ACCUM with dump_valid=1 -> all outputs 0 in the same cycle and state IDLE.
REQ-037 start, prn_in=5, period_in=1, dump_ready=1, accumulator +3 per clk -> first dump one clk after the 2nd epoch, dump_data = 3 x clks between the epochs, track_prn=5.
REQ-038 period_in=0 and period_in=3 -> dumps every 1 and every 3 epochs respectively.
REQ-039 accumulator crosses 0xFFFF->0x0000 inside a period -> dump_data equals the true signed sum modulo 2^16.
REQ-040 dump_ready held 0 across two dump epochs -> first dump_data held, overrun=1, overrun_count=1 (macro defined), and a later start clears both.
REQ-041 stop mid-period with dump pending -> track_enable=0 next clk, dump_valid stays 1 until dump_ready, no further dumps.

Source files
------------

// File: rtl/accum_dump_ctrl.sv
// Dump controller for a GPS tracking channel: arms on start, aligns to C/A code epochs and
// emits accumulator deltas every N code periods. Define DUMP_OVERRUN_COUNT_EN to add overrun_count.
module accum_dump_ctrl #(
  parameter int ACC_WIDTH    = 16,
  parameter int PERIOD_WIDTH = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    stop,
  input  logic [4:0]              prn_in,
  input  logic [PERIOD_WIDTH-1:0] period_in,
  input  logic [9:0]              code_shift,
  input  logic [ACC_WIDTH-1:0]    accumulator,
  output logic                    track_enable,
  output logic [4:0]              track_prn,
  output logic [ACC_WIDTH-1:0]    dump_data,
  output logic                    dump_valid,
  input  logic                    dump_ready,
  output logic                    overrun,
`ifdef DUMP_OVERRUN_COUNT_EN
  output logic [7:0]              overrun_count,
`endif
  output logic                    busy
);

  typedef enum logic [1:0] {IDLE, ARM, ACCUM} state_t;

  state_t                  state_reg, state_next;
  logic [1:0]              run_sync_reg;
  logic                    run_ok;
  logic [9:0]              prev_cs_reg;
  logic                    epoch;
  logic [ACC_WIDTH-1:0]    base_reg;
  logic [ACC_WIDTH-1:0]    data_reg;
  logic                    valid_reg;
  logic                    overrun_reg;
  logic [4:0]              prn_reg;
  logic [PERIOD_WIDTH-1:0] period_reg;
  logic [PERIOD_WIDTH-1:0] count_reg;
  logic [PERIOD_WIDTH-1:0] count_inc;
  logic                    dump_hit;
  logic                    start_accept;
  logic                    base_load;
  logic                    count_step;
  logic                    dump_epoch;
  logic                    dump_drop;

  // Reset asserts asynchronously but releases the FSM only after two clean clock edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) run_sync_reg <= 2'b00;
    else       run_sync_reg <= {run_sync_reg[0], 1'b1};
  end
  assign run_ok = run_sync_reg[1];

  assign epoch     = (code_shift == '0) && (prev_cs_reg != '0);
  assign count_inc = count_reg + PERIOD_WIDTH'(1);
  assign dump_hit  = (count_inc == period_reg);
  assign dump_drop = valid_reg && !dump_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Stop wins over both start and an epoch landing in the same cycle.
  always_comb begin
    state_next   = state_reg;
    start_accept = 1'b0;
    base_load    = 1'b0;
    count_step   = 1'b0;
    dump_epoch   = 1'b0;
    track_enable = (state_reg != IDLE);
    busy         = (state_reg != IDLE);
    case (state_reg)
      IDLE: begin
        if (start && !stop && run_ok) begin
          state_next   = ARM;
          start_accept = 1'b1;
        end
      end
      ARM: begin
        if (stop) begin
          state_next = IDLE;
        end else if (epoch) begin
          state_next = ACCUM;
          base_load  = 1'b1;
        end
      end
      ACCUM: begin
        if (stop) begin
          state_next = IDLE;
        end else if (epoch) begin
          if (dump_hit) dump_epoch = 1'b1;
          else          count_step = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_cs_reg <= '0;
      base_reg    <= '0;
      data_reg    <= '0;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
      prn_reg     <= '0;
      period_reg  <= '0;
      count_reg   <= '0;
    end else begin
      prev_cs_reg <= code_shift;
      if (start_accept) begin
        prn_reg     <= prn_in;
        period_reg  <= (period_in == '0) ? PERIOD_WIDTH'(1) : period_in;
        count_reg   <= '0;
        overrun_reg <= 1'b0;
      end
      if (base_load) begin
        base_reg  <= accumulator;
        count_reg <= '0;
      end
      if (count_step) count_reg <= count_inc;
      // Base always advances so the next period stays aligned even when this dump is dropped.
      if (dump_epoch) begin
        base_reg  <= accumulator;
        count_reg <= '0;
        if (dump_drop) begin
          overrun_reg <= 1'b1;
        end else begin
          data_reg  <= accumulator - base_reg;
          valid_reg <= 1'b1;
        end
      end else if (valid_reg && dump_ready) begin
        valid_reg <= 1'b0;
      end
    end
  end

`ifdef DUMP_OVERRUN_COUNT_EN
  logic [7:0] ocnt_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ocnt_reg <= '0;
    end else if (start_accept) begin
      ocnt_reg <= '0;
    end else if (dump_epoch && dump_drop && (ocnt_reg != 8'hFF)) begin
      ocnt_reg <= ocnt_reg + 8'd1;
    end
  end
  assign overrun_count = ocnt_reg;
`endif

  assign track_prn  = prn_reg;
  assign dump_data  = data_reg;
  assign dump_valid = valid_reg;
  assign overrun    = overrun_reg;

endmodule

// File: tb/tb_accum_dump_ctrl.sv
// Randomized bench for accum_dump_ctrl against a transaction-level model that sums the
// accumulator increments between code epochs. Honours DUMP_OVERRUN_COUNT_EN like the design.
module tb_accum_dump_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        stop;
  logic [4:0]  prn_in;
  logic [1:0]  period_in;
  logic [9:0]  code_shift;
  logic [15:0] accumulator;
  logic        track_enable;
  logic [4:0]  track_prn;
  logic [15:0] dump_data;
  logic        dump_valid;
  logic        dump_ready;
  logic        overrun;
  logic        busy;
`ifdef DUMP_OVERRUN_COUNT_EN
  logic [7:0]  overrun_count;
`endif

  always #5 clk = ~clk;

  accum_dump_ctrl #(.ACC_WIDTH(16), .PERIOD_WIDTH(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stop         (stop),
    .prn_in       (prn_in),
    .period_in    (period_in),
    .code_shift   (code_shift),
    .accumulator  (accumulator),
    .track_enable (track_enable),
    .track_prn    (track_prn),
    .dump_data    (dump_data),
    .dump_valid   (dump_valid),
    .dump_ready   (dump_ready),
    .overrun      (overrun),
`ifdef DUMP_OVERRUN_COUNT_EN
    .overrun_count(overrun_count),
`endif
    .busy         (busy)
  );

  int vectors_applied = 0;
  int miscompares     = 0;

  // Stimulus generators
  int          cs_cnt;
  int          cs_len;
  logic [15:0] acc_v;

  // Reference model: channel armed/aligned flags, epochs since last dump and the true sum of
  // accumulator increments since the last aligned epoch.
  bit          m_active;
  bit          m_based;
  logic [4:0]  m_prn;
  int          m_period;
  int          m_epochs;
  int          m_sum;
  bit          m_valid;
  logic [15:0] m_data;
  bit          m_over;
  int          m_ocnt;
  int          m_rel;
  int          m_prev_cs;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors_applied++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("track_enable", 32'(track_enable), 32'(m_active));
    check("busy",         32'(busy),         32'(m_active));
    check("track_prn",    32'(track_prn),    32'(m_prn));
    check("dump_valid",   32'(dump_valid),   32'(m_valid));
    check("dump_data",    32'(dump_data),    32'(m_data));
    check("overrun",      32'(overrun),      32'(m_over));
`ifdef DUMP_OVERRUN_COUNT_EN
    check("overrun_count", 32'(overrun_count), 32'(m_ocnt));
`endif
  endtask

  task automatic model_edge(input bit st, input bit sp, input bit rdy, input int inc);
    bit ep;
    ep = (code_shift == 10'd0) && (m_prev_cs != 0);
    m_prev_cs = int'(code_shift);
    m_sum += inc;
    if (m_valid && rdy) begin
      $display("xfer data=%04h", m_data);
      m_valid = 1'b0;
    end
    if (!m_active) begin
      if (st && !sp && m_rel >= 2) begin
        m_active = 1'b1;
        m_based  = 1'b0;
        m_prn    = prn_in;
        m_period = (period_in == 2'd0) ? 1 : int'(period_in);
        m_epochs = 0;
        m_over   = 1'b0;
        m_ocnt   = 0;
      end
    end else if (sp) begin
      m_active = 1'b0;
    end else if (ep) begin
      if (!m_based) begin
        m_based = 1'b1;
        m_epochs = 0;
        m_sum = 0;
      end else begin
        m_epochs++;
        if (m_epochs == m_period) begin
          m_epochs = 0;
          if (m_valid) begin
            m_over = 1'b1;
            if (m_ocnt < 255) m_ocnt++;
          end else begin
            m_valid = 1'b1;
            m_data  = 16'(m_sum);
          end
          m_sum = 0;
        end
      end
    end
    if (m_rel < 10) m_rel++;
  endtask

  // One clock: check state left by the previous edge, drive new inputs, advance the model.
  task automatic step(input bit st, input bit sp, input bit rdy, input int inc);
    check_outputs();
    start      = st;
    stop       = sp;
    dump_ready = rdy;
    cs_cnt     = (cs_cnt + 1 >= cs_len) ? 0 : cs_cnt + 1;
    code_shift = 10'(cs_cnt);
    acc_v      = acc_v + 16'(inc);
    accumulator = acc_v;
    model_edge(st, sp, rdy, inc);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    #2 reset = 1'b1;
    #1;
    check("rst_track_enable", 32'(track_enable), 32'd0);
    check("rst_busy",         32'(busy),         32'd0);
    check("rst_track_prn",    32'(track_prn),    32'd0);
    check("rst_dump_valid",   32'(dump_valid),   32'd0);
    check("rst_dump_data",    32'(dump_data),    32'd0);
    check("rst_overrun",      32'(overrun),      32'd0);
`ifdef DUMP_OVERRUN_COUNT_EN
    check("rst_overrun_count", 32'(overrun_count), 32'd0);
`endif
    start = 1'b0; stop = 1'b0; dump_ready = 1'b0;
    cs_cnt = 0; code_shift = 10'd0;
    m_active = 0; m_based = 0; m_prn = '0; m_period = 1; m_epochs = 0; m_sum = 0;
    m_valid = 0; m_data = '0; m_over = 0; m_ocnt = 0; m_prev_cs = 0; m_rel = 0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; stop = 1'b0; dump_ready = 1'b0;
    prn_in = '0; period_in = '0; code_shift = '0;
    acc_v = '0; accumulator = '0; cs_cnt = 0; cs_len = 4;
    apply_reset();

    // Start right after reset release must be ignored until the release is synchronized.
    prn_in = 5'd5; period_in = 2'd1;
    step(1, 0, 1, 3);
    step(0, 0, 1, 3);
    step(1, 0, 1, 3);
    for (int i = 0; i < 20; i++) step(0, 0, 1, 3);
    check("first_dump_data", 32'(dump_data), 32'd12);
    check("first_track_prn", 32'(track_prn), 32'd5);
    step(0, 1, 1, 3);

    // Period 0 (means 1) then period 3 with random increments.
    prn_in = 5'd9; period_in = 2'd0;
    step(1, 0, 1, 5);
    for (int i = 0; i < 16; i++) step(0, 0, 1, $urandom_range(0, 200) - 100);
    step(0, 1, 1, 0);
    prn_in = 5'd17; period_in = 2'd3;
    step(1, 0, 1, 1);
    for (int i = 0; i < 40; i++) step(0, 0, 1, $urandom_range(0, 200) - 100);
    step(0, 1, 1, 0);

    // Accumulator wraps through 0xFFFF inside a period.
    acc_v = 16'hFFE0;
    step(1, 0, 1, 7);
    for (int i = 0; i < 30; i++) step(0, 0, 1, 7);
    step(0, 1, 1, 0);

    // Consumer stalls across several dump epochs.
    prn_in = 5'd3; period_in = 2'd1;
    step(1, 0, 0, 2);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 2);
    check("ovr_flag_set", 32'(overrun), 32'd1);
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    check("ovr_cleared_by_start", 32'(overrun), 32'd0);
    step(0, 1, 1, 0);
    step(0, 0, 1, 0);

    // Stop with a dump pending.
    period_in = 2'd2;
    step(1, 0, 0, 4);
    for (int i = 0; i < 40 && !m_valid; i++) step(0, 0, 0, 4);
    check("pend_valid_before_stop", 32'(dump_valid), 32'd1);
    step(0, 1, 0, 4);
    check("stop_track_enable", 32'(track_enable), 32'd0);
    for (int i = 0; i < 12; i++) step(0, 0, 0, 4);
    check("pend_valid_held", 32'(dump_valid), 32'd1);
    step(0, 0, 1, 4);
    step(0, 0, 0, 4);
    check("pend_valid_dropped", 32'(dump_valid), 32'd0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      int inc;
      if ($urandom_range(0, 99) == 0) cs_len = $urandom_range(2, 9);
      prn_in    = 5'($urandom);
      period_in = 2'($urandom);
      inc = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 60000)) - 30000
                                        : int'($urandom_range(0, 400)) - 200;
      step($urandom_range(0, 29) == 0, $urandom_range(0, 59) == 0,
           $urandom_range(0, 2) != 0, inc);
    end
    step(0, 1, 1, 0);

    // Reset while accumulating with a dump pending.
    period_in = 2'd1; cs_len = 4;
    step(1, 0, 0, 3);
    for (int i = 0; i < 12; i++) step(0, 0, 0, 3);
    check("pre_reset_valid", 32'(dump_valid), 32'd1);
    apply_reset();
    for (int i = 0; i < 4; i++) step(0, 0, 0, 3);
    check_outputs();

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
